pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer and a synchronous flush. It replaces fixed-field, load-enabled stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB. Any stage payload (control word, PC, operands, rd, instruction) is packed into one WIDTH-bit bus. Stalls propagate back one stage per cycle with no combinational ready path, and branch mispredicts squash the stage in one cycle.

## Interface
Parameters:
- WIDTH, 32, payload bits per entry (1..512)
- RESET_VAL, '0, payload value held in both entries after reset/flush (WIDTH bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high; one clock, synchronous active-high reset
- flush  in  1  squash all held entries (mispredict/trap)
- in_valid  in  1  upstream presents a payload
- in_ready  out  1  stage can accept; registered, never depends combinationally on out_ready
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage presents a payload
- out_ready  in  1  downstream accepts this cycle
- out_data  out  WIDTH  payload to downstream
- occupancy  out  2  entries held: 0, 1 or 2

## Operation
- Storage: main entry (drives out_data) plus skid entry; each has a valid bit. Strict FIFO order.
- States: EMPTY (no entries), ONE (main valid), FULL (main and skid valid). occupancy = 0/1/2 respectively.
- in_ready = (state != FULL). out_valid = (state != EMPTY). out_data = main payload.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept -> main <= in_data, ONE.
- ONE: accept & drain -> main <= in_data, ONE. Accept only -> skid <= in_data, FULL. Drain only -> EMPTY.
- FULL: drain -> main <= skid, ONE. No drain -> hold. in_valid is ignored (in_ready=0).
- Payload bits of empty entries hold their last value. The bench checks data only when valid.
- flush (rst low): next state EMPTY and both payloads <= RESET_VAL. Any accept or drain in the same cycle is discarded. The upstream handshake still completes, because in_ready was 1. Downstream must not consume out_data on a flush cycle; the consumer qualifies with its own flush.
- rst has priority over flush. Both force the same end state.

## Timing
- Reset values: out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL, first cycle after rst deasserts.
- Latency: accepted payload appears on out_data the next cycle (1-cycle stage).
- Throughput: 1 payload/cycle while out_ready=1.
- Backpressure: out_ready low for one cycle costs no bubble. in_ready falls one cycle after the skid fills and rises the cycle after the first drain from FULL.
- Simultaneous accept+drain in ONE: occupancy unchanged, main updated, no bubble.
- in_valid low with out_ready high: drains one entry per cycle to EMPTY.
- Reset or flush mid-burst: all in-flight entries lost. The cycle after, out_valid=0 and in_ready=1.
- Payload X on in_data with in_valid=0 must not propagate to out_data.

## Structure
- Shared package pipe_pkg: stage_state_e enum {EMPTY, ONE, FULL} (2 bits) and the per-stage payload typedefs/widths (e.g. EX_MEM_W). Callers pack and unpack rv32i_control_word and data fields into WIDTH.
- Payload entries use the existing parametrised `register` module, two instances at width WIDTH.
- The next-state/enable logic for those two instances stays inline; no further sub-modules.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF. Required after rst drops: out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
- Streaming: out_ready=1, send 0x1..0x8 on consecutive cycles. Required: each appears exactly one cycle later, in order, with occupancy staying 1 and no bubbles.
- Backpressure:
  - Send 0xA, 0xB, 0xC with out_ready=0 throughout. Required: 0xA and 0xB accepted, occupancy=2, in_ready=0, and 0xC held upstream.
  - Then raise out_ready. Required: drains 0xA, 0xB, 0xC in order with in_ready=1 one cycle after the first drain.
- Simultaneous accept+drain in ONE: hold 0x10, then in_valid=1 with 0x11 and out_ready=1. Required: next cycle out_data=0x11, occupancy=1.
- Flush in FULL while in_valid=1 with 0x99. Required: next cycle out_valid=0, occupancy=0, in_ready=1, and 0x99 never appears on out_data.
- Random: out_ready and in_valid each random at 50% for 10k cycles with WIDTH=97, compared against a queue model. Required: no loss, duplication or reordering, and occupancy never exceeds 2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: handshake stage state and packed payload widths
// for the classic five-stage stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Packed payload widths; callers pack control words and data fields into these.
  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 128;
  localparam int unsigned EX_MEM_W = 97;
  localparam int unsigned MEM_WB_W = 72;

  function automatic logic [1:0] occupancy_of(input stage_state_e s);
    case (s)
      ONE:     occupancy_of = 2'd1;
      FULL:    occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_register.sv
// Parametrised load-enabled register with synchronous active-high reset.
module register #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer
// and synchronous flush; in_ready is decoded from registered state only.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_e     r_state;
  stage_state_e     w_state_next;
  logic             w_accept;
  logic             w_drain;
  logic             w_main_load;
  logic             w_skid_load;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_skid_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = w_main_q;
  assign occupancy = occupancy_of(r_state);

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  always_comb begin
    w_state_next = r_state;
    w_main_load  = 1'b0;
    w_skid_load  = 1'b0;
    w_main_d     = in_data;
    w_skid_d     = in_data;
    if (flush) begin
      // Squash discards any same-cycle accept or drain.
      w_state_next = EMPTY;
      w_main_load  = 1'b1;
      w_skid_load  = 1'b1;
      w_main_d     = RESET_VAL;
      w_skid_d     = RESET_VAL;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_main_load  = 1'b1;
            w_state_next = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load  = 1'b1;
            w_state_next = FULL;
          end else if (w_drain) begin
            w_state_next = EMPTY;
          end
        end
        FULL: begin
          if (w_drain) begin
            w_main_load  = 1'b1;
            w_main_d     = w_skid_q;
            w_state_next = ONE;
          end
        end
        default: begin
          w_state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  register #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  register #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_d    (w_skid_d),
    .o_q    (w_skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised check of pipe_skid_stage at WIDTH=97 against
// hand-computed values and a queue model.
module tb_pipe_skid_stage;

  localparam int unsigned W  = 97;
  localparam logic [W-1:0] RV = 97'h1_0000_0000_0000_0000_0000_A5A5;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  logic [W-1:0] model_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick(input string what);
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d %s: in_v=%0b in_d=%0h out_r=%0b -> out_v=%0b out_d=%0h occ=%0d in_r=%0b",
             n_txn, what, in_valid, in_data, out_ready, out_valid, out_data, occupancy, in_ready);
  endtask

  task automatic expect_state(input string tag, input logic ov, input logic ir,
                              input logic [1:0] occ);
    check_eq({tag, ".out_valid"}, W'(out_valid), W'(ov));
    check_eq({tag, ".in_ready"},  W'(in_ready),  W'(ir));
    check_eq({tag, ".occupancy"}, W'(occupancy), W'(occ));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = W'(32'hDEAD_BEEF); out_ready = 1'b0;
    tick("reset");
    tick("reset");
    rst = 1'b0; in_valid = 1'b0;
    expect_state("reset", 1'b0, 1'b1, 2'd0);
    check_eq("reset.out_data", out_data, RV);

    // Streaming: each payload visible one cycle later, no bubbles.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      tick("stream");
      expect_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
      check_eq($sformatf("stream%0d.data", i), out_data, W'(i));
    end
    in_valid = 1'b0;
    tick("stream_drain");
    expect_state("stream_drain", 1'b0, 1'b1, 2'd0);

    // Backpressure fills the skid; 0xC stays upstream.
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'hA);
    tick("bp_a");
    expect_state("bp_a", 1'b1, 1'b1, 2'd1);
    check_eq("bp_a.data", out_data, W'(8'hA));
    in_data = W'(8'hB);
    tick("bp_b");
    expect_state("bp_b", 1'b1, 1'b0, 2'd2);
    check_eq("bp_b.data", out_data, W'(8'hA));
    in_data = W'(8'hC);
    tick("bp_c_held");
    expect_state("bp_c_held", 1'b1, 1'b0, 2'd2);
    check_eq("bp_c_held.data", out_data, W'(8'hA));
    out_ready = 1'b1;
    tick("bp_drain_a");
    expect_state("bp_drain_a", 1'b1, 1'b1, 2'd1);
    check_eq("bp_drain_a.data", out_data, W'(8'hB));
    tick("bp_drain_b");
    expect_state("bp_drain_b", 1'b1, 1'b1, 2'd1);
    check_eq("bp_drain_b.data", out_data, W'(8'hC));
    in_valid = 1'b0;
    tick("bp_drain_c");
    expect_state("bp_drain_c", 1'b0, 1'b1, 2'd0);

    // Simultaneous accept and drain in ONE.
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h10);
    tick("sim_10");
    check_eq("sim_10.data", out_data, W'(8'h10));
    in_data = W'(8'h11); out_ready = 1'b1;
    tick("sim_11");
    expect_state("sim_11", 1'b1, 1'b1, 2'd1);
    check_eq("sim_11.data", out_data, W'(8'h11));
    in_valid = 1'b0;
    tick("sim_drain");
    expect_state("sim_drain", 1'b0, 1'b1, 2'd0);

    // Flush in FULL with 0x99 offered.
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h20);
    tick("fl_20");
    in_data = W'(8'h21);
    tick("fl_21");
    expect_state("fl_full", 1'b1, 1'b0, 2'd2);
    in_data = W'(8'h99); flush = 1'b1;
    tick("flush_full");
    expect_state("flush_full", 1'b0, 1'b1, 2'd0);
    check_eq("flush_full.data", out_data, RV);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick("post_flush");
    expect_state("post_flush", 1'b0, 1'b1, 2'd0);

    // Flush in ONE discards a same-cycle accept.
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h30);
    tick("fl1_30");
    in_data = W'(8'h98); flush = 1'b1;
    tick("flush_one");
    expect_state("flush_one", 1'b0, 1'b1, 2'd0);
    check_eq("flush_one.data", out_data, RV);
    flush = 1'b0; in_valid = 1'b0;

    // Reset wins over flush; both land in the reset state.
    in_valid = 1'b1; in_data = W'(8'h40);
    tick("pre_rst");
    rst = 1'b1; flush = 1'b1; in_data = W'(8'h41);
    tick("rst_flush");
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    expect_state("rst_flush", 1'b0, 1'b1, 2'd0);
    check_eq("rst_flush.data", out_data, RV);

    // Random traffic against a queue model.
    model_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic acc;
      logic drn;
      check_eq("rnd.occupancy", W'(occupancy), W'(model_q.size()));
      check_eq("rnd.out_valid", W'(out_valid), W'(model_q.size() != 0));
      check_eq("rnd.in_ready",  W'(in_ready),  W'(model_q.size() < 2));
      if (model_q.size() != 0) check_eq("rnd.out_data", out_data, model_q[0]);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = W'({$urandom, $urandom, $urandom, $urandom});
      acc = in_valid && (model_q.size() < 2);
      drn = out_ready && (model_q.size() != 0);
      if (drn) void'(model_q.pop_front());
      if (acc) model_q.push_back(in_data);
      @(posedge clk);
      #1;
    end
    $display("random phase done: 10000 cycles, %0d entries left in model", model_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
